// File: rtl/sys_timer.sv
// Programmable down-counter timer with maskable IRQ, CTRL/PRESET/COUNT word registers.
// Latency: register writes land on the next clk edge; Dout and IRQ are combinational.
// Backpressure: none, the bus access always completes in one cycle.
module sys_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        irq_flag, irq_flag_nxt;
    logic        clr_en;
    logic        en;
    logic        auto_rld;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unused_addr;

    assign en          = ctrl[0];
    assign auto_rld    = (ctrl[2:1] == 2'b01);
    assign wr_ctrl     = WE && (Addr[3:2] == 2'b00);
    assign wr_preset   = WE && (Addr[3:2] == 2'b01);
    assign unused_addr = ^Addr[31:4];

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        irq_flag_nxt = irq_flag;
        clr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt    = preset;
                irq_flag_nxt = 1'b0;
                state_nxt    = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // PRESET of 0 or 1 both expire here, one cycle after LOAD
                    count_nxt    = 32'd0;
                    irq_flag_nxt = 1'b1;
                    state_nxt    = INT;
                end
            end
            INT: begin
                state_nxt = IDLE;
                if (auto_rld) irq_flag_nxt = 1'b0;
                else          clr_en       = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            irq_flag <= irq_flag_nxt;
        end
    end

    // A bus write to CTRL wins over the one-shot Enable clear
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl   <= 4'd0;
            preset <= 32'd0;
        end else begin
            if (wr_ctrl)     ctrl    <= Din[3:0];
            else if (clr_en) ctrl[0] <= 1'b0;
            if (wr_preset)   preset  <= Din;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'b00:   Dout = {28'd0, ctrl};
            2'b01:   Dout = preset;
            2'b10:   Dout = count;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_sys_timer.sv
// Bench for sys_timer: directed scenarios plus random bus traffic against a timeline model.
module tb_sys_timer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    int seq [6] = '{3, 2, 1, 0, 0, 0};

    sys_timer dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference model: a run starts at edge s when idle sees Enable; COUNT=P at s+1,
    // counts down to 1, expires at s+1+max(P,1), and the edge after expiry is the
    // wrap-up edge (one-shot drops Enable, auto-reload drops the flag).
    logic [31:0] m_ctrl = '0;
    logic [31:0] m_pre  = '0;
    logic [31:0] m_cnt  = '0;
    bit          m_flag = 1'b0;
    bit          m_run  = 1'b0;
    bit          m_post = 1'b0;
    longint      t = 0;
    longint      s = 0;
    longint      lp = 1;

    always @(posedge clk) begin : model
        bit m_en;
        bit m_auto;
        bit m_clr;
        t++;
        m_en   = m_ctrl[0];
        m_auto = (m_ctrl[2:1] == 2'b01);
        m_clr  = 1'b0;
        if (reset) begin
            m_ctrl = '0; m_pre = '0; m_cnt = '0;
            m_flag = 1'b0; m_run = 1'b0; m_post = 1'b0;
        end else begin
            if (m_post) begin
                m_post = 1'b0;
                if (m_auto) m_flag = 1'b0;
                else        m_clr  = 1'b1;
            end else if (!m_run) begin
                if (m_en) begin
                    m_run = 1'b1;
                    s = t;
                end
            end else if (t == s + 1) begin
                m_cnt  = m_pre;
                m_flag = 1'b0;
                lp     = (m_pre < 32'd2) ? 64'd1 : longint'(m_pre);
            end else if (!m_en) begin
                m_run = 1'b0;
            end else if (t < s + 1 + lp) begin
                m_cnt = 32'(lp - (t - s - 1));
            end else begin
                m_cnt  = '0;
                m_flag = 1'b1;
                m_run  = 1'b0;
                m_post = 1'b1;
            end
            if (WE && Addr[3:2] == 2'd0)      m_ctrl = {28'd0, Din[3:0]};
            else if (m_clr)                   m_ctrl[0] = 1'b0;
            if (WE && Addr[3:2] == 2'd1)      m_pre = Din;
        end
    end

    function automatic logic [31:0] m_read(input logic [1:0] sel);
        case (sel)
            2'd0:    return {28'd0, m_ctrl[3:0]};
            2'd1:    return m_pre;
            2'd2:    return m_cnt;
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("dout_vs_model", Dout, m_read(Addr[3:2]));
            check("irq_vs_model", {31'd0, IRQ}, {31'd0, m_flag & m_ctrl[3]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus(input logic [1:0] sel, input logic we, input logic [31:0] d);
        Addr = {28'($urandom), sel};
        WE   = we;
        Din  = d;
        tick(1);
        WE   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        WE        = 1'b0;
        Addr[3:2] = sel;
        #1;
        check(tag, Dout, exp);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        WE    = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(1);
        do_reset();
        chk_on = 1'b1;

        // reset values, PRESET written with Enable low
        rd("rst_ctrl", 2'd0, 32'd0);
        rd("rst_preset", 2'd1, 32'd0);
        rd("rst_count", 2'd2, 32'd0);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        bus(2'd1, 1'b1, 32'h0000000F);
        rd("preset_rd", 2'd1, 32'h0000000F);
        tick(10);
        rd("idle_count", 2'd2, 32'd0);
        check("idle_irq", {31'd0, IRQ}, 32'd0);

        // one-shot, P=15: IRQ on the 17th edge after the CTRL write
        bus(2'd0, 1'b1, 32'h9);
        tick(2);
        rd("os_count_p", 2'd2, 32'h0000000F);
        tick(1);
        rd("os_count_dec", 2'd2, 32'h0000000E);
        tick(13);
        check("os_irq_e16", {31'd0, IRQ}, 32'd0);
        tick(1);
        check("os_irq_e17", {31'd0, IRQ}, 32'd1);
        rd("os_count_zero", 2'd2, 32'd0);
        tick(1);
        rd("os_ctrl_clr", 2'd0, 32'h8);
        tick(5);
        check("os_irq_hold", {31'd0, IRQ}, 32'd1);

        // auto-reload, P=3: 1-cycle IRQ every 6 cycles, COUNT 3,2,1,0,0,0
        do_reset();
        bus(2'd1, 1'b1, 32'd3);
        bus(2'd0, 1'b1, 32'hB);
        Addr[3:2] = 2'd2;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check("ar_irq", {31'd0, IRQ}, {31'd0, (k % 6 == 5)});
            check("ar_count", Dout, (k == 1) ? 32'd0 : 32'(seq[(k - 2) % 6]));
        end

        // masked expiry, then unmasking exposes the pending flag
        do_reset();
        bus(2'd1, 1'b1, 32'd2);
        bus(2'd0, 1'b1, 32'h1);
        tick(5);
        check("mask_irq", {31'd0, IRQ}, 32'd0);
        rd("mask_count", 2'd2, 32'd0);
        bus(2'd0, 1'b1, 32'h8);
        check("unmask_irq", {31'd0, IRQ}, 32'd1);

        // disable mid-count freezes COUNT, re-enable reloads
        do_reset();
        bus(2'd1, 1'b1, 32'd10);
        bus(2'd0, 1'b1, 32'h1);
        tick(6);
        rd("mid_count6", 2'd2, 32'd6);
        bus(2'd0, 1'b1, 32'h0);
        tick(3);
        rd("frozen_count", 2'd2, 32'd5);
        check("frozen_irq", {31'd0, IRQ}, 32'd0);
        bus(2'd0, 1'b1, 32'h1);
        tick(2);
        rd("reload_count", 2'd2, 32'd10);

        // COUNT write ignored, unused slot, CTRL upper bits
        bus(2'd0, 1'b1, 32'h0);
        tick(2);
        rd("stop_count", 2'd2, 32'd9);
        bus(2'd2, 1'b1, 32'h00001234);
        rd("cnt_wr_ign", 2'd2, 32'd9);
        bus(2'd3, 1'b1, 32'hDEADBEEF);
        rd("unused_rd", 2'd3, 32'd0);
        rd("unused_preset", 2'd1, 32'd10);
        bus(2'd0, 1'b1, 32'hFFFFFFFF);
        rd("ctrl_mask", 2'd0, 32'h0000000F);

        // random traffic, checked every cycle against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [1:0]  sel;
            logic [31:0] d;
            sel = 2'($urandom_range(0, 3));
            d   = (sel == 2'd1) ? 32'($urandom_range(0, 9)) : $urandom;
            reset = ($urandom_range(0, 249) == 0);
            Addr  = {28'($urandom), sel};
            WE    = ($urandom_range(0, 3) == 0);
            Din   = d;
            tick(1);
        end
        reset = 1'b0;
        WE    = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sys_timer.md
Name: sys_timer

Overview:
- Memory-mapped programmable down-counter timer for the MIPS CPU system bridge.
- Three word registers: CTRL, PRESET and COUNT. Counts down from PRESET and raises a maskable interrupt request (IRQ) at expiry.
- Two modes: one-shot, and auto-reload (periodic).
- Upper address bits are decoded externally by the bridge; this block decodes only Addr[3:2].

Parameters:
- None.

Ports:
- clk    input   1    system clock; all state updates on rising edge
- reset  input   1    synchronous, active-high reset
- Addr   input   30   word address, bits [31:2]; only Addr[3:2] used
- WE     input   1    write enable for the selected register
- Din    input   32   write data
- Dout   output  32   read data, combinational from Addr[3:2]
- IRQ    output  1    interrupt request = irq_flag AND CTRL.IM

Behaviour:
- Register map (Addr[3:2]):
  - 00 = CTRL (byte offset 0x0)
  - 01 = PRESET (0x4)
  - 10 = COUNT (0x8, read-only)
  - 11 = unused; reads 0, writes ignored
- CTRL[0] Enable; CTRL[2:1] Mode (01 = auto-reload, any other value = one-shot); CTRL[3] IM (interrupt mask, 1 = allow). CTRL[31:4] always read 0.
- Writes (WE=1, registered on clk edge):
  - CTRL <= {28'b0, Din[3:0]}
  - PRESET <= Din
  - writes to COUNT are ignored
  - a bus write to CTRL takes priority over the FSM clearing Enable in the same cycle
- Dout: CTRL zero-extended, PRESET, COUNT, or 0; purely combinational, no latency.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, so IRQ=0.
- FSM, evaluated each edge from current register values:
  - IDLE: if Enable go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; irq_flag <= 0; go to CNT.
  - CNT:
    - if Enable=0, go to IDLE with COUNT frozen;
    - else if COUNT > 1, COUNT <= COUNT-1;
    - else COUNT <= 0, irq_flag <= 1, go to INT.
  - INT:
    - one-shot: clear CTRL.Enable, go to IDLE; irq_flag stays 1 until the next LOAD or reset;
    - auto-reload: irq_flag <= 0, go to IDLE; Enable is still set, so the next cycle goes to LOAD.
- Timing, with PRESET=P and Enable written at edge E0:
  - LOAD at E1
  - COUNT=P at E2
  - COUNT=1 at E(P+1)
  - COUNT=0, irq_flag=1 at E(P+2)
- Auto-reload: IRQ is a 1-cycle pulse with period P+3 cycles.
- PRESET of 0 or 1: expiry at E(P+2) with P treated as 1, i.e. IRQ at E3.
- IM=0 masks IRQ without affecting irq_flag; setting IM later exposes a pending flag.
- Changing PRESET mid-count does not affect the current COUNT; it takes effect at the next LOAD.
- Reset mid-operation returns everything to reset values at that edge.

Test Plan:
- Reset, then write PRESET=0x0000000F with Enable=0 -> Dout at PRESET reads 0xF; COUNT stays 0; IRQ stays 0 indefinitely.
- PRESET=0xF, write CTRL=0x9 (one-shot, IM=1, Enable) ->
  - COUNT=0xF two edges later, decrementing by 1 per cycle;
  - IRQ=1 at the 17th edge after the CTRL write and stays 1;
  - CTRL reads 0x8 after the following edge.
- PRESET=3, CTRL=0xB (auto-reload, IM=1, Enable) -> IRQ 1-cycle pulses every 6 cycles; COUNT sequence 3,2,1,0 repeating.
- CTRL=0x1 (IM=0) with PRESET=2 -> IRQ stays 0 at expiry; then write CTRL=0x8 -> IRQ=1 immediately (combinational after the write edge).
- Enable mid-count (PRESET=10), then write CTRL=0x0 when COUNT=6 -> COUNT frozen at 6 or 5 (depending on the edge), IRQ 0; re-enable -> reload to 10.
- Write CTRL=0xFFFFFFFF -> reads 0x0000000F. Write to COUNT, or read Addr[3:2]=11 -> COUNT unchanged; read returns 0.
